// File: rtl/big_tx.sv
// rtl/big_tx.sv - snapshots a WIDTH-bit value and sends it MSB byte first as 8N1 UART bytes
module big_tx #(
    parameter int WIDTH    = 128,
    parameter int NBYTES   = 16,
    parameter int BAUD_DIV = 104
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             send,
    input  logic [WIDTH-1:0] big,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BYTE_LAST = CW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]    byte_cnt_q, byte_cnt_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [7:0] cur_byte;
    logic       baud_end;

    assign cur_byte = shift_q[WIDTH-1 -: 8];
    assign baud_end = (baud_cnt_q == BAUD_LAST);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // tx_d is the line level for the next bit period, so the line lags state by nothing.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (send) begin
                    shift_d    = big;
                    busy_d     = 1'b1;
                    byte_cnt_d = '0;
                    baud_cnt_d = '0;
                    state_d    = START;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = DATA;
                    tx_d       = cur_byte[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = cur_byte[bit_cnt_q + 3'd1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_cnt_d = '0;
                    if (byte_cnt_q < BYTE_LAST) begin
                        shift_d    = shift_q << 8;
                        byte_cnt_d = byte_cnt_q + CW'(1);
                        state_d    = START;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_big_tx.sv
// tb/tb_big_tx.sv - scoreboard bench for big_tx with a UART byte decoder
module tb_big_tx;
    localparam int BD    = 4;
    localparam int FRAME = 16 * 10 * BD;

    logic         clk = 1'b0;
    logic         nRst = 1'b0;
    logic         send = 1'b0;
    logic [127:0] big = '0;
    logic         tx, busy, done;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_cnt = 0;
    int rx_cnt = 0;
    logic [7:0] exp_q[$];

    big_tx #(.WIDTH(128), .NBYTES(16), .BAUD_DIV(BD)) dut (
        .clk(clk), .nRst(nRst), .send(send), .big(big),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // UART decoder: samples mid-bit on falling edges, pops the scoreboard per byte
    bit       m_active = 0;
    int       m_cnt = 0;
    logic [7:0] m_byte = '0;
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (!nRst) begin
            m_active = 0;
        end else if (!m_active) begin
            if (tx === 1'b0) begin
                m_active = 1;
                m_cnt = 0;
            end
        end else begin
            m_cnt++;
            if (m_cnt >= BD + BD/2 && m_cnt < 9*BD && ((m_cnt - BD/2) % BD) == 0)
                m_byte[(m_cnt - BD/2)/BD - 1] = tx;
            if (m_cnt == 9*BD + BD/2) begin
                m_active = 0;
                rx_cnt++;
                total_cnt++;
                if (tx !== 1'b1)
                    $display("FAIL stop_bit: got %b want 1", tx);
                else if (exp_q.size() == 0)
                    $display("FAIL rx_unexpected: got %h want none", m_byte);
                else if (m_byte !== exp_q[0])
                    $display("FAIL rx_byte: got %h want %h", m_byte, exp_q[0]);
                else
                    pass_cnt++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
    end

    task automatic push_bytes(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v[127 - 8*i -: 8]);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 2*FRAME) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Starts a frame; returns cycles from tx falling to done rising
    task automatic run_frame(input logic [127:0] v, input bit zap, output int n);
        push_bytes(v, 16);
        @(negedge clk);
        big = v;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        if (zap) big = '0;
        total_cnt++;
        if (tx !== 1'b0 || busy !== 1'b1)
            $display("FAIL start_latency: got tx=%b busy=%b want tx=0 busy=1", tx, busy);
        else pass_cnt++;
        wait_done(n);
    endtask

    task automatic test_reset;
        nRst = 1'b0;
        send = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
                $display("FAIL reset_outputs: got tx=%b busy=%b done=%b want 1 0 0", tx, busy, done);
            else pass_cnt++;
        end
        send = 1'b0;
        nRst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (tx !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_release: got tx=%b busy=%b want 1 0", tx, busy);
        else pass_cnt++;
    endtask

    task automatic test_basic;
        int n, d0, r0;
        d0 = done_cnt;
        r0 = rx_cnt;
        run_frame(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0, n);
        total_cnt++;
        if (n !== FRAME) $display("FAIL basic_duration: got %0d want %0d", n, FRAME);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL basic_done_width: got done=%b busy=%b want 0 0", done, busy);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt - d0 != 1 || rx_cnt - r0 != 16 || exp_q.size() != 0)
            $display("FAIL basic_counts: got done=%0d bytes=%0d left=%0d want 1 16 0",
                     done_cnt - d0, rx_cnt - r0, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_snapshot;
        int n;
        run_frame({128{1'b1}}, 1'b1, n);
        @(negedge clk);
        total_cnt++;
        if (n !== FRAME || exp_q.size() != 0)
            $display("FAIL snapshot: got cycles=%0d left=%0d want %0d 0", n, exp_q.size(), FRAME);
        else pass_cnt++;
    endtask

    task automatic test_ignore_busy;
        int n, d0;
        bit busy_drop, extra;
        logic [127:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        d0 = done_cnt;
        busy_drop = 0;
        extra = 0;
        push_bytes(v, 16);
        @(negedge clk);
        big = v;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 2*FRAME) begin
            if (busy !== 1'b1) busy_drop = 1;
            send = (n == 100);
            @(negedge clk);
            n++;
        end
        send = 1'b0;
        total_cnt++;
        if (busy_drop || n !== FRAME)
            $display("FAIL ignore_busy: got drop=%0b cycles=%0d want 0 %0d", busy_drop, n, FRAME);
        else pass_cnt++;
        for (int i = 0; i < 3*10*BD; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) extra = 1;
        end
        total_cnt++;
        if (extra || done_cnt - d0 != 1 || exp_q.size() != 0)
            $display("FAIL ignore_single: got extra=%0b done=%0d left=%0d want 0 1 0",
                     extra, done_cnt - d0, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int n1, n2;
        logic [127:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        push_bytes(v, 16);
        push_bytes(v, 16);
        @(negedge clk);
        big = v;
        send = 1'b1;
        @(negedge clk);
        wait_done(n1);
        total_cnt++;
        if (n1 !== FRAME || tx !== 1'b1)
            $display("FAIL b2b_first: got cycles=%0d tx=%b want %0d 1", n1, tx, FRAME);
        else pass_cnt++;
        @(negedge clk);
        send = 1'b0;
        total_cnt++;
        if (tx !== 1'b0 || busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_gap: got tx=%b busy=%b done=%b want 0 1 0", tx, busy, done);
        else pass_cnt++;
        wait_done(n2);
        @(negedge clk);
        total_cnt++;
        if (n2 !== FRAME || exp_q.size() != 0)
            $display("FAIL b2b_second: got cycles=%0d left=%0d want %0d 0", n2, exp_q.size(), FRAME);
        else pass_cnt++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_abort;
        int n, r0;
        logic [127:0] v;
        v = 128'hA5C3_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2;
        r0 = rx_cnt;
        push_bytes(v, 5);
        @(negedge clk);
        big = v;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (5*10*BD + 4*BD + BD/2) @(negedge clk);
        #1 nRst = 1'b0;
        #1;
        total_cnt++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_async: got tx=%b busy=%b done=%b want 1 0 0", tx, busy, done);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (rx_cnt - r0 != 5 || exp_q.size() != 0 || tx !== 1'b1)
            $display("FAIL abort_partial: got bytes=%0d left=%0d tx=%b want 5 0 1",
                     rx_cnt - r0, exp_q.size(), tx);
        else pass_cnt++;
        run_frame(~v, 1'b0, n);
        @(negedge clk);
        total_cnt++;
        if (n !== FRAME || exp_q.size() != 0)
            $display("FAIL abort_recover: got cycles=%0d left=%0d want %0d 0", n, exp_q.size(), FRAME);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_snapshot();
        test_ignore_busy();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
